// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : stream_rr_arbiter
// Brief   : Round-robin N_REQ:1 valid/ready stream arbiter with a registered
//           grant. Define STREAM_ARB_BURST_EN to hold a grant for up to
//           MAX_BURST beats before rotating.
// Revision: 1.0 - initial release
// ============================================================================
module stream_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         s_valid,
  input  logic [N_REQ*DW-1:0]      s_data,
  output logic [N_REQ-1:0]         s_ready,
  output logic                     m_valid,
  output logic [DW-1:0]            m_data,
  input  logic                     m_ready,
  output logic [$clog2(N_REQ)-1:0] m_id
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [IW-1:0] w_gnt_inc, w_start, w_winner;
  logic          w_found, w_hs, w_keep;

  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return sum[IW-1:0];
  endfunction

  assign w_gnt_inc = f_wrap(r_gnt, 1);
  assign w_start   = (r_state == ST_IDLE) ? r_ptr : w_gnt_inc;
  assign w_hs      = (r_state == ST_GRANT) & s_valid[r_gnt] & m_ready;

  // Scan downward so the index closest to w_start is the last to win.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (s_valid[f_wrap(w_start, i)]) begin
        w_found  = 1'b1;
        w_winner = f_wrap(w_start, i);
      end
    end
  end

`ifdef STREAM_ARB_BURST_EN
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [BW-1:0] r_burst_cnt, w_burst_nxt;

  assign w_keep = (r_burst_cnt < BW'(MAX_BURST - 1));

  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (w_hs) begin
      w_burst_nxt = w_keep ? r_burst_cnt + 1'b1 : '0;
    end else if (w_state_nxt == ST_IDLE) begin
      w_burst_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else begin
      r_burst_cnt <= w_burst_nxt;
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    m_valid     = 1'b0;
    m_data      = '0;
    m_id        = '0;
    s_ready     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_winner;
        end
      end
      ST_GRANT: begin
        m_valid          = s_valid[r_gnt];
        m_data           = s_data[r_gnt*DW +: DW];
        m_id             = r_gnt;
        s_ready[r_gnt]   = m_ready;
        if (!s_valid[r_gnt]) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hs && !w_keep) begin
          // Search already started at gnt+1, so it wraps back to gnt if alone.
          w_ptr_nxt = w_gnt_inc;
          if (w_found) begin
            w_gnt_nxt = w_winner;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// Self-checking bench for stream_rr_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin reference model.
module tb_stream_rr_arbiter;

  localparam int N         = 4;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;
  localparam int IW        = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      s_valid;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic              m_ready;
  logic [IW-1:0]     m_id;

  int checks = 0;
  int errors = 0;

  // Reference model: owner = granted master or -1, ptr = search start, beats = beats this grant
  int mdl_owner, mdl_ptr, mdl_beats;

  stream_rr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .m_id(m_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = '0; s_data = '0; m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = '1; m_ready = 1'b1;
    for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 32'hA0 + i;
    #12;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b expected 0", m_valid); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_s_ready: got %b expected 0000", s_ready); end
    checks++; if (m_id !== 2'd0) begin errors++; $display("FAIL rst_m_id: got %0d expected 0", m_id); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_m_data: got %0h expected 0", m_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_release_latency: got m_valid %0b expected 0", m_valid); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_id !== 2'd0) begin
      errors++; $display("FAIL rst_first_grant: got valid %0b id %0d expected valid 1 id 0", m_valid, m_id);
    end
  endtask

  task automatic test_single_master();
    do_reset();
    s_valid = 4'b0100; s_data[2*DW +: DW] = 32'd1; m_ready = 1'b1; #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got m_valid %0b expected 0", m_valid); end
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      s_data[2*DW +: DW] = b;
      #1;
      checks++; if (m_valid !== 1'b1 || m_id !== 2'd2 || m_data !== b) begin
        errors++; $display("FAIL single_beat%0d: got valid %0b id %0d data %0h expected 1 2 %0h", b, m_valid, m_id, m_data, b);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_id;
    do_reset();
    s_valid = '1; m_ready = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
`ifdef STREAM_ARB_BURST_EN
      exp_id = (i / MAX_BURST) % N;
`else
      exp_id = i % N;
`endif
      checks++; if (m_valid !== 1'b1 || m_id !== IW'(exp_id)) begin
        errors++; $display("FAIL rr_seq%0d: got valid %0b id %0d expected valid 1 id %0d", i, m_valid, m_id, exp_id);
      end
    end
  endtask

  task automatic test_backpressure();
    logic seen;
    do_reset();
    s_valid = 4'b0010; s_data[1*DW +: DW] = 32'h5; s_data[3*DW +: DW] = 32'h33; m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) s_valid[3] = 1'b1;
      #1;
      checks++; if (m_valid !== 1'b1 || m_id !== 2'd1 || m_data !== 32'h5 || s_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d: got valid %0b id %0d data %0h ready %b expected 1 1 5 0000",
                           c, m_valid, m_id, m_data, s_ready);
      end
    end
    @(negedge clk); m_ready = 1'b1; #1;
    checks++; if (s_ready !== 4'b0010 || m_data !== 32'h5) begin
      errors++; $display("FAIL bp_release: got ready %b data %0h expected 0010 5", s_ready, m_data);
    end
    @(negedge clk); s_valid[1] = 1'b0;
`ifdef STREAM_ARB_BURST_EN
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      #1;
      if (m_valid === 1'b1 && m_id === 2'd3 && m_data === 32'h33) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_next_id: got id %0d valid %0b expected id 3", m_id, m_valid); end
`else
    seen = 1'b0; #1;
    checks++; if (m_valid !== 1'b1 || m_id !== 2'd3 || m_data !== 32'h33) begin
      errors++; $display("FAIL bp_next_id: got valid %0b id %0d data %0h expected 1 3 33 (seen %0b)", m_valid, m_id, m_data, seen);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    s_valid = '1; m_ready = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 4'b0000 || m_id !== 2'd0 || m_data !== 32'h0) begin
      errors++; $display("FAIL async_rst: got valid %0b ready %b id %0d data %0h expected 0 0000 0 0",
                         m_valid, s_ready, m_id, m_data);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL async_rst_idle: got m_valid %0b expected 0", m_valid); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_id !== 2'd0) begin
      errors++; $display("FAIL async_rst_regrant: got valid %0b id %0d expected 1 0", m_valid, m_id);
    end
  endtask

  task automatic test_random();
    logic          exp_valid;
    logic [IW-1:0] exp_id;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  exp_ready;
    do_reset();
    mdl_owner = -1; mdl_ptr = 0; mdl_beats = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        s_valid[i] = ($urandom_range(0, 99) < 55);
        s_data[i*DW +: DW] = $urandom();
      end
      m_ready = ($urandom_range(0, 99) < 65);
      #1;
      exp_valid = 1'b0; exp_id = '0; exp_data = '0; exp_ready = '0;
      if (mdl_owner >= 0) begin
        exp_valid = s_valid[mdl_owner];
        exp_id    = IW'(mdl_owner);
        exp_data  = s_data[mdl_owner*DW +: DW];
        exp_ready[mdl_owner] = m_ready;
      end
      checks++; if (m_valid !== exp_valid) begin errors++; $display("FAIL rand_valid@%0d: got %0b expected %0b", c, m_valid, exp_valid); end
      checks++; if (m_id !== exp_id) begin errors++; $display("FAIL rand_id@%0d: got %0d expected %0d", c, m_id, exp_id); end
      checks++; if (m_data !== exp_data) begin errors++; $display("FAIL rand_data@%0d: got %0h expected %0h", c, m_data, exp_data); end
      checks++; if (s_ready !== exp_ready) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", c, s_ready, exp_ready); end
      // Advance the model to the state after the coming rising edge.
      if (mdl_owner < 0) begin
        mdl_owner = rr_pick(s_valid, mdl_ptr);
        mdl_beats = 0;
      end else if (!s_valid[mdl_owner]) begin
        mdl_owner = -1;
        mdl_beats = 0;
      end else if (m_ready) begin
`ifdef STREAM_ARB_BURST_EN
        if (mdl_beats + 1 < MAX_BURST) begin
          mdl_beats++;
        end else begin
          mdl_ptr = (mdl_owner + 1) % N; mdl_owner = rr_pick(s_valid, mdl_ptr); mdl_beats = 0;
        end
`else
        mdl_ptr = (mdl_owner + 1) % N; mdl_owner = rr_pick(s_valid, mdl_ptr); mdl_beats = 0;
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
